luma_interp_2d: RTL

Parametrised successor to the 8-wide horizontal subpixel interpolator. Performs full separable HEVC 8-tap luma interpolation on a BLK_W x BLK_H block at any quarter-pel (frac_x, frac_y). Rows stream in and out over valid/ready handshakes. An internal 7-row window of horizontal results feeds the vertical filter. Sits between the reference-row fetch and the prediction output buffer.

---
 rtl/luma_interp_pkg.sv | 61 ++++++
 rtl/luma_fir8.sv | 35 +++
 rtl/luma_interp_2d.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/luma_interp_pkg.sv
// luma_interp_pkg
// Shared constants for the separable HEVC 8-tap luma interpolator:
// filter coefficients per quarter-pel phase, FSM state encoding,
// intermediate/accumulator widths, rounding constants and shifts,
// plus the coefficient lookup and output clip helpers.
package luma_interp_pkg;

  // Horizontal intermediate (H) width and vertical accumulator (V) width.
  localparam int IW = 16;
  localparam int VW = 24;

  // Rounding offsets and arithmetic shifts for the two output paths.
  localparam logic signed [VW-1:0] RND_H = 24'sd32;
  localparam logic signed [VW-1:0] RND_V = 24'sd2048;
  localparam int unsigned SH_H = 6;
  localparam int unsigned SH_V = 12;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_PRIME = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Tap t multiplies pixel k = j + t.
  localparam logic signed [7:0] COEF_A [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58,
                                                8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam logic signed [7:0] COEF_B [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40,
                                                8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam logic signed [7:0] COEF_C [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17,
                                                8'sd58, -8'sd10, 8'sd4, -8'sd1};

  // Phase 0 is expressed as a single 64 weight on the centre tap so the
  // integer case shares the MAC datapath (pixel << 6).
  function automatic logic signed [7:0] fir_coef(input logic [1:0] phase,
                                                 input logic [2:0] tap);
    logic signed [7:0] c;
    c = 8'sd0;
    case (phase)
      2'd1:    c = COEF_A[tap];
      2'd2:    c = COEF_B[tap];
      2'd3:    c = COEF_C[tap];
      default: c = (tap == 3'd3) ? 8'sd64 : 8'sd0;
    endcase
    return c;
  endfunction

  // Saturate a signed rounded value to an 8-bit pixel.
  function automatic logic [7:0] clip8(input logic signed [VW-1:0] v);
    logic [7:0] p;
    if (v < 24'sd0) begin
      p = 8'd0;
    end else if (v > 24'sd255) begin
      p = 8'd255;
    end else begin
      p = v[7:0];
    end
    return p;
  endfunction

endpackage

// File: rtl/luma_fir8.sv
// luma_fir8
// Combinational signed 8-tap multiply-accumulate.
// Ports:
//   phase_i : quarter-pel phase selecting the coefficient set
//   ops_i   : eight signed operands, operand t at [t*OPW +: OPW]
//   sum_o   : signed sum of coef[t] * operand[t]
module luma_fir8
  import luma_interp_pkg::*;
#(
  parameter int OPW  = 9,
  parameter int ACCW = 16
) (
  input  logic [1:0]              phase_i,
  input  logic [8*OPW-1:0]        ops_i,
  output logic signed [ACCW-1:0]  sum_o
);

  logic signed [ACCW-1:0] acc_s;
  logic signed [ACCW-1:0] coef_s;
  logic signed [ACCW-1:0] opnd_s;

  // Sign-extend each coefficient and operand to the accumulator width and sum.
  always_comb begin
    acc_s  = '0;
    coef_s = '0;
    opnd_s = '0;
    for (int t = 0; t < 8; t++) begin
      coef_s = ACCW'(fir_coef(phase_i, 3'(t)));
      opnd_s = ACCW'(signed'(ops_i[t*OPW +: OPW]));
      acc_s  = acc_s + coef_s * opnd_s;
    end
    sum_o = acc_s;
  end

endmodule

// File: rtl/luma_interp_2d.sv
// luma_interp_2d
// Separable HEVC 8-tap luma interpolator for a BLK_W x BLK_H block at any
// quarter-pel (frac_x, frac_y). Each accepted reference row is filtered
// horizontally; a 7-row window of horizontal results plus the current row
// feeds the vertical filter. One output row is registered per accepted row
// once the window is primed.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   start, frac_x, frac_y  : block start and phases (sampled on start in IDLE)
//   busy                   : block in progress
//   in_valid/in_ready/in_row     : reference row stream, pixel k at [k*PIX_W +: PIX_W]
//   out_valid/out_ready/out_row  : interpolated row stream, pixel j at [j*PIX_W +: PIX_W]
//   out_last               : marks the final row of the block
//   done                   : one-cycle pulse after the final output handshake
module luma_interp_2d
  import luma_interp_pkg::*;
#(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 frac_x,
  input  logic [1:0]                 frac_y,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [(BLK_W+7)*PIX_W-1:0] in_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BLK_W*PIX_W-1:0]     out_row,
  output logic                       out_last,
  output logic                       done
);

  localparam int OUT_W  = BLK_W * PIX_W;
  localparam int HROW_W = BLK_W * IW;
  localparam int CW     = 7;
  localparam logic [CW-1:0] N_IN_V   = CW'(BLK_H + 7);
  localparam logic [CW-1:0] N_IN_H   = CW'(BLK_H);
  localparam logic [CW-1:0] LAST_OUT = CW'(BLK_H - 1);

  state_t              state_q, state_d;
  logic [1:0]          fx_q, fx_d;
  logic [1:0]          fy_q, fy_d;
  logic [CW-1:0]       rows_in_q, rows_in_d;
  logic [CW-1:0]       rows_out_q, rows_out_d;
  logic [HROW_W-1:0]   win_q [7];
  logic [HROW_W-1:0]   win_d [7];
  logic [OUT_W-1:0]    out_row_q, out_row_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [HROW_W-1:0]   h_row_s;
  logic [OUT_W-1:0]    pix_row_s;
  logic [CW-1:0]       n_in_s;
  logic                in_ready_s;
  logic                in_fire_s;
  logic                out_fire_s;

  // win_q[0] is the oldest row (r-7), win_q[6] is r-1; the current row's
  // horizontal result supplies the eighth vertical tap directly.
  for (genvar j = 0; j < BLK_W; j++) begin : g_col
    logic [8*(PIX_W+1)-1:0]  h_ops_s;
    logic [8*IW-1:0]         v_ops_s;
    logic signed [IW-1:0]    h_sum_s;
    logic signed [VW-1:0]    v_sum_s;
    logic signed [VW-1:0]    h_rnd_s;
    logic signed [VW-1:0]    v_rnd_s;

    for (genvar t = 0; t < 8; t++) begin : g_tap
      assign h_ops_s[t*(PIX_W+1) +: (PIX_W+1)] = {1'b0, in_row[(j+t)*PIX_W +: PIX_W]};
      if (t < 7) begin : g_win
        assign v_ops_s[t*IW +: IW] = win_q[t][j*IW +: IW];
      end else begin : g_cur
        assign v_ops_s[t*IW +: IW] = h_sum_s;
      end
    end

    luma_fir8 #(.OPW(PIX_W + 1), .ACCW(IW)) u_fir_h (
      .phase_i (fx_q),
      .ops_i   (h_ops_s),
      .sum_o   (h_sum_s)
    );

    luma_fir8 #(.OPW(IW), .ACCW(VW)) u_fir_v (
      .phase_i (fy_q),
      .ops_i   (v_ops_s),
      .sum_o   (v_sum_s)
    );

    assign h_row_s[j*IW +: IW] = h_sum_s;
    assign h_rnd_s = (VW'(h_sum_s) + RND_H) >>> SH_H;
    assign v_rnd_s = (v_sum_s + RND_V) >>> SH_V;
    assign pix_row_s[j*PIX_W +: PIX_W] = (fy_q == 2'd0) ? PIX_W'(clip8(h_rnd_s))
                                                        : PIX_W'(clip8(v_rnd_s));
  end

  assign n_in_s     = (fy_q == 2'd0) ? N_IN_H : N_IN_V;
  assign in_ready_s = busy_q && ((state_q == S_PRIME) || (state_q == S_RUN)) &&
                      (rows_in_q < n_in_s) && (!out_valid_q || out_ready);
  assign in_fire_s  = in_valid && in_ready_s;
  assign out_fire_s = out_valid_q && out_ready;

  // Next-state logic: block control, row counters, window shift, output row.
  always_comb begin
    state_d     = state_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    rows_in_d   = rows_in_q;
    rows_out_d  = rows_out_q;
    out_row_d   = out_row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    for (int i = 0; i < 7; i++) begin
      win_d[i] = win_q[i];
    end

    if (in_fire_s) begin
      for (int i = 0; i < 6; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[6]  = h_row_s;
      rows_in_d = rows_in_q + 7'd1;
    end else begin
      rows_in_d = rows_in_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fx_d       = frac_x;
          fy_d       = frac_y;
          rows_in_d  = 7'd0;
          rows_out_d = 7'd0;
          busy_d     = 1'b1;
          state_d    = (frac_y != 2'd0) ? S_PRIME : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIME: begin
        if (in_fire_s && (rows_in_q == 7'd6)) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PRIME;
        end
      end
      S_RUN: begin
        if (out_fire_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rows_out_d  = rows_out_q + 7'd1;
        end else begin
          rows_out_d = rows_out_q;
        end
        // A new row may be accepted on the same edge the previous one drains.
        if (in_fire_s) begin
          out_row_d   = pix_row_s;
          out_valid_d = 1'b1;
          out_last_d  = ((rows_in_q + 7'd1) == n_in_s);
        end else begin
          out_row_d = out_row_q;
        end
        if (out_fire_s && (rows_out_q == LAST_OUT)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fx_q        <= 2'd0;
      fy_q        <= 2'd0;
      rows_in_q   <= 7'd0;
      rows_out_q  <= 7'd0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      rows_in_q   <= rows_in_d;
      rows_out_q  <= rows_out_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 7; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
